fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and produces the pc_inc value that the execute stage consumes. It also consumes the execute stage's branch outcome (Zero, Target) and the decode stage's jump to redirect fetch. It drives a ready-handshaked instruction memory and holds the IF/ID pipeline register, with a one-entry buffer for responses that arrive during a stall.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a ready-handshaked instruction
// memory and holds the IF/ID pipeline register. A one-entry buffer keeps a
// response that completes while the hazard unit is stalling. Taken branches
// from EX and jumps from ID redirect the fetch stream.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_branch,
   input  logic        ex_zero,
   input  logic [31:0] ex_target,
   input  logic        id_jump,
   input  logic [25:0] id_jidx,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc_inc,
   output logic        if_valid,
   output logic        flush
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned JIDX_W = 26;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DROP  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   redir_pc;
   logic [XLEN-1:0]   hold_instr;
   logic [XLEN-1:0]   hold_pc_inc;

   logic              ex_redir;
   logic              id_redir;
   logic              redirect;
   logic [XLEN-1:0]   tgt;
   logic [XLEN-1:0]   pc_inc;
   logic [JIDX_W-1:0] jidx;
   logic              load_mem;
   logic              load_hold;

   // Redirect resolution: the EX branch is the older instruction and wins.
   assign ex_redir = ex_branch & ex_zero;
   assign id_redir = id_jump & if_valid & ~stall & ~ex_redir;
   assign redirect = ex_redir | id_redir;
   assign jidx     = id_jidx;
   assign tgt      = ex_redir ? ex_target : {if_pc_inc[31:28], jidx, 2'b00};
   assign pc_inc   = pc + XLEN'(4);

   // IF/ID load sources: a fresh memory response or the stall buffer.
   assign load_mem  = (state == S_FETCH) & imem_ready & ~redirect & ~stall;
   assign load_hold = (state == S_HOLD) & ~redirect & ~stall;

   // Memory request side; the request is held stable on pc until ready.
   assign imem_req  = ~rst & (state != S_HOLD);
   assign imem_addr = pc;

   // Kill the younger instruction already moving into ID/EX.
   assign flush = ex_redir;

   // Fetch FSM, PC, stall buffer and pending redirect target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         redir_pc    <= '0;
         hold_instr  <= '0;
         hold_pc_inc <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  if (redirect) begin
                     pc <= tgt;
                  end else if (stall) begin
                     hold_instr  <= imem_rdata;
                     hold_pc_inc <= pc_inc;
                     pc          <= pc_inc;
                     state       <= S_HOLD;
                  end else begin
                     pc <= pc_inc;
                  end
               end else if (redirect) begin
                  // Outstanding request cannot be withdrawn; remember where to go.
                  redir_pc <= tgt;
                  state    <= S_DROP;
               end
            end
            S_DROP: begin
               if (imem_ready) begin
                  pc    <= redirect ? tgt : redir_pc;
                  state <= S_FETCH;
               end else if (redirect) begin
                  redir_pc <= tgt;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc    <= tgt;
                  state <= S_FETCH;
               end else if (!stall) begin
                  state <= S_FETCH;
               end
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

   // IF/ID register: redirect squashes, stall holds, otherwise load or bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid  <= 1'b0;
         if_instr  <= '0;
         if_pc_inc <= '0;
      end else if (redirect) begin
         if_valid <= 1'b0;
      end else if (stall) begin
         if_valid <= if_valid;
      end else if (load_mem) begin
         if_instr  <= imem_rdata;
         if_pc_inc <= pc_inc;
         if_valid  <= 1'b1;
      end else if (load_hold) begin
         if_instr  <= hold_instr;
         if_pc_inc <= hold_pc_inc;
         if_valid  <= 1'b1;
      end else begin
         if_valid <= 1'b0;
      end
   end

endmodule
